chunked_adder: RTL



---
 rtl/chunked_adder.sv | 133 +++++++++++++
 1 files changed

// File: rtl/chunked_adder.sv
// rtl/chunked_adder.sv - multi-cycle adder, CHUNK bits per clock, registered inter-chunk carry
// Optional subtract mode under ADDER_SUB_EN (adds the sub port).
module chunked_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
`ifdef ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry_out;
  logic             r_overflow;
  logic             r_zero;

  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin_eff;
  logic [CHUNK-1:0] w_a_slice;
  logic [CHUNK-1:0] w_b_slice;
  logic [CHUNK:0]   w_chunk;
  logic [WIDTH-1:0] w_sum_next;
  logic             w_last;
  logic             w_msb_cin;

  // Subtraction folds into the operand latch: store ~b and force the carry to 1.
`ifdef ADDER_SUB_EN
  assign w_b_eff   = sub ? ~b : b;
  assign w_cin_eff = sub ? 1'b1 : carry_in;
`else
  assign w_b_eff   = b;
  assign w_cin_eff = carry_in;
`endif

  assign w_last    = (r_idx == LAST_IDX);
  assign w_a_slice = r_a[r_idx*CHUNK +: CHUNK];
  assign w_b_slice = r_b[r_idx*CHUNK +: CHUNK];
  assign w_chunk   = {1'b0, w_a_slice} + {1'b0, w_b_slice} + {{CHUNK{1'b0}}, r_carry};

  always_comb begin
    w_sum_next = r_sum;
    w_sum_next[r_idx*CHUNK +: CHUNK] = w_chunk[CHUNK-1:0];
  end

  // Carry into the MSB recovered from the MSB sum bit, valid on the last chunk.
  assign w_msb_cin = r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_sum_next[WIDTH-1];

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_next_state = S_RUN;
      S_RUN:   if (w_last)    w_next_state = S_DONE;
      S_DONE:  if (out_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a         <= '0;
      r_b         <= '0;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      r_sum       <= '0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
      r_zero      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= w_b_eff;
            r_carry <= w_cin_eff;
            r_idx   <= '0;
          end
        end
        S_RUN: begin
          r_sum   <= w_sum_next;
          r_carry <= w_chunk[CHUNK];
          r_idx   <= r_idx + 1'b1;
          if (w_last) begin
            r_carry_out <= w_chunk[CHUNK];
            r_overflow  <= w_msb_cin ^ w_chunk[CHUNK];
            r_zero      <= (w_sum_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum       = r_sum;
  assign carry_out = r_carry_out;
  assign overflow  = r_overflow;
  assign zero      = r_zero;

endmodule
